// File: rtl/byte_lane_regbank.sv
// byte_lane_regbank
//   Register bank of DEPTH entries, DATA_W bits wide. Writes are byte-lane
//   masked. Reads are registered and take one cycle. A bulk clear walks the
//   entries, zeroing one entry per cycle.
//
//   Optional feature: define BYTE_LANE_REGBANK_BYPASS_EN to enable a
//   read-after-write bypass. With the bypass, a read and a write to the same
//   address in the same cycle return the new byte lanes. Without it, that
//   read returns the pre-write contents.
//
// Ports
//   clk        clock; all state changes on its rising edge
//   reset      synchronous, active-low reset
//   wr_valid   write request
//   wr_ready   write accept (low while a bulk clear runs)
//   wr_addr    write entry index
//   wr_be      per-lane write enable; bit i covers wr_data[8i+7:8i]
//   wr_data    write data
//   rd_en      read request
//   rd_addr    read entry index
//   rd_valid   one-cycle pulse, marks rd_data as new
//   rd_data    registered read data; holds its value between reads
//   clr_start  start a bulk clear (ignored while one is running)
//   busy       bulk clear in progress
//   dirty      per-entry flag: entry written since the last clear or reset
//
// States
//   IDLE  | normal operation, writes accepted
//   CLEAR | walking clr_idx over all entries, zeroing each one
module byte_lane_regbank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [$clog2(DEPTH)-1:0]        wr_addr,
  input  logic [DATA_W/8-1:0]             wr_be,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            rd_en,
  input  logic [$clog2(DEPTH)-1:0]        rd_addr,
  output logic                            rd_valid,
  output logic [DATA_W-1:0]               rd_data,
  input  logic                            clr_start,
  output logic                            busy,
  output logic [DEPTH-1:0]                dirty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NB     = DATA_W / 8;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_accept;
  logic [DATA_W-1:0]   rd_word;

  assign busy      = (state == CLEAR);
  assign wr_ready  = !busy;
  assign wr_accept = wr_valid && wr_ready;

  // Read data as it will be registered at the next edge.
  always_comb begin
    rd_word = mem[rd_addr];
`ifdef BYTE_LANE_REGBANK_BYPASS_EN
    if (wr_accept && (rd_addr == wr_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      clr_idx  <= '0;
      dirty    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_word;

      case (state)
        IDLE: begin
          // A write in the same cycle as clr_start commits here and is
          // overwritten later by the clear walk.
          if (wr_accept) begin
            for (int i = 0; i < NB; i++) begin
              if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
            if (|wr_be) dirty[wr_addr] <= 1'b1;
          end
          if (clr_start) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        CLEAR: begin
          mem[clr_idx]   <= '0;
          dirty[clr_idx] <= 1'b0;
          clr_idx        <= clr_idx + 1'b1;
          if (clr_idx == ADDR_W'(DEPTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_lane_regbank.sv
module tb_byte_lane_regbank;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int NB     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [NB-1:0]     wr_be;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              clr_start;
  logic              busy;
  logic [DEPTH-1:0]  dirty;

  byte_lane_regbank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .clr_start(clr_start), .busy(busy), .dirty(dirty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain arrays plus a count of clear cycles remaining.
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DEPTH-1:0]  m_dirty;
  int                m_clr_left;
  logic              m_rd_valid;
  logic [DATA_W-1:0] m_rd_data;

`ifdef BYTE_LANE_REGBANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [NB-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit acc;
    if (!reset) begin
      for (int e = 0; e < DEPTH; e++) m_mem[e] = '0;
      m_dirty    = '0;
      m_clr_left = 0;
      m_rd_valid = 1'b0;
      m_rd_data  = '0;
      return;
    end
    acc = wr_valid && (m_clr_left == 0);
    m_rd_valid = rd_en;
    if (rd_en) begin
      if (BYPASS && acc && rd_addr == wr_addr)
        m_rd_data = merge(m_mem[rd_addr], wr_data, wr_be);
      else
        m_rd_data = m_mem[rd_addr];
    end
    if (acc && wr_be != 0) begin
      m_mem[wr_addr]   = merge(m_mem[wr_addr], wr_data, wr_be);
      m_dirty[wr_addr] = 1'b1;
    end
    if (m_clr_left > 0) begin
      m_mem[DEPTH - m_clr_left]   = '0;
      m_dirty[DEPTH - m_clr_left] = 1'b0;
      m_clr_left--;
    end else if (clr_start) begin
      m_clr_left = DEPTH;
    end
  endtask

  // Apply current inputs at the next edge, then compare all outputs.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("busy",     32'(busy),     32'(m_clr_left != 0));
    check("wr_ready", 32'(wr_ready), 32'(m_clr_left == 0));
    check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    check("rd_data",  rd_data,       m_rd_data);
    check("dirty",    32'(dirty),    32'(m_dirty));
  endtask

  task automatic quiet();
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; clr_start = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d, input logic [NB-1:0] be);
    quiet(); wr_valid = 1'b1; wr_addr = ADDR_W'(a); wr_data = d; wr_be = be;
    step();
  endtask

  task automatic do_read(input int a);
    quiet(); rd_en = 1'b1; rd_addr = ADDR_W'(a);
    step();
  endtask

  int busy_cnt;

  initial begin
    quiet();
    #1;
    reset = 1'b0;
    step(); step();
    quiet();
    step();
    check("reset_dirty", 32'(dirty), 32'h0);
    check("reset_ready", 32'(wr_ready), 32'h1);
    check("reset_busy", 32'(busy), 32'h0);

    // Lane-masked writes then read
    do_write(3, 32'hAABBCCDD, 4'hF);
    do_write(3, 32'h11223344, 4'h5);
    do_read(3);
    check("lane_merge_data", rd_data, 32'hAA22CC44);
    check("lane_merge_valid", 32'(rd_valid), 32'h1);
    check("lane_merge_dirty", 32'(dirty), 32'h08);
    quiet(); step();
    check("rd_valid_pulse", 32'(rd_valid), 32'h0);
    check("rd_data_hold", rd_data, 32'hAA22CC44);

    // Zero byte-enable write
    do_write(2, 32'hFFFFFFFF, 4'h0);
    do_read(2);
    check("be0_data", rd_data, 32'h0);
    check("be0_dirty", 32'(dirty[2]), 32'h0);

    // Fill then bulk clear; clr_start repeated mid-clear
    for (int e = 0; e < DEPTH; e++) do_write(e, 32'h1000_0000 + e, 4'hF);
    check("fill_dirty", 32'(dirty), 32'hFF);
    quiet(); clr_start = 1'b1; step();
    busy_cnt = 0;
    for (int c = 0; c < 2 * DEPTH; c++) begin
      if (busy) busy_cnt++;
      quiet(); clr_start = (c == 3); wr_valid = 1'b1; wr_be = 4'hF;
      wr_data = 32'hDEAD0000; wr_addr = ADDR_W'(7);
      if (!busy) wr_valid = 1'b0;
      step();
    end
    check("clear_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    check("clear_dirty", 32'(dirty), 32'h0);
    for (int e = 0; e < DEPTH; e++) begin
      do_read(e);
      check("clear_read", rd_data, 32'h0);
    end

    // Same-cycle read/write to one address
    do_write(5, 32'h12345678, 4'hF);
    quiet(); wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 32'hCAFEBABE; wr_be = 4'h3;
    rd_en = 1'b1; rd_addr = 3'd5;
    step();
    check("raw_same_cycle", rd_data, BYPASS ? 32'h1234BABE : 32'h12345678);
    do_read(5);
    check("raw_after", rd_data, 32'h1234BABE);

    // Reset in the middle of a clear
    quiet(); clr_start = 1'b1; step();
    quiet(); step(); step();
    check("midclr_busy", 32'(busy), 32'h1);
    quiet(); reset = 1'b0; step();
    check("midclr_reset_busy", 32'(busy), 32'h0);
    quiet(); step();
    check("midclr_ready", 32'(wr_ready), 32'h1);
    check("midclr_dirty", 32'(dirty), 32'h0);
    do_read(6);
    check("midclr_entry", rd_data, 32'h0);

    // Reads during a clear
    for (int e = 0; e < DEPTH; e++) do_write(e, 32'h5A5A5A5A, 4'hF);
    quiet(); clr_start = 1'b1; step();
    quiet(); step();
    do_read(0);
    check("clr_read_e0", rd_data, 32'h0);
    do_read(7);
    check("clr_read_e7", rd_data, 32'h5A5A5A5A);
    quiet();
    for (int c = 0; c < DEPTH; c++) step();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      reset     = ($urandom_range(0, 199) != 0);
      wr_valid  = $urandom_range(0, 1);
      wr_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_be     = NB'($urandom);
      wr_data   = $urandom;
      rd_en     = $urandom_range(0, 1);
      rd_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      clr_start = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
